// File: rtl/sram_2p_ctrl_pkg.sv
// sram_2p_ctrl_pkg: shared defaults, response tag type and clog2 helper for sram_2p_ctrl
package sram_2p_ctrl_pkg;
  localparam int DW_DEF = 128;
  localparam int DEPTH_DEF = 1296;
  localparam int AW_DEF = 11;
  localparam int IDW_DEF = 2;
  typedef struct packed {
    logic [IDW_DEF-1:0] id;
    logic               err;
    logic               bypass;
  } tag_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over N requesters
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   req_i    : request vector
//   acc_i    : grant was taken this cycle; pointer moves past the winner
//   gnt_o    : one-hot grant (zero when no request), combinational
module rr_arbiter
  import sram_2p_ctrl_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  input  logic         acc_i,
  output logic [N-1:0] gnt_o
);
  localparam int PW = N > 1 ? clog2(N) : 1;
  logic [PW-1:0] ptr_q, ptr_d;
  int idx;
  // scan from the highest offset down so the requester nearest the pointer wins last
  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_q) + k) % N;
      if (req_i[idx]) begin
        gnt_o = '0;
        gnt_o[idx] = 1'b1;
        ptr_d = PW'((idx + 1) % N);
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (acc_i) ptr_q <= ptr_d;
  end
endmodule

// File: rtl/sram_2p_ctrl.sv
// sram_2p_ctrl: arbitrated read/write front end for a registered-read two-port SRAM macro
//   CE, RST            : clock, synchronous active-high reset
//   RD_VALID/ADDR/READY: NR read requesters, round-robin arbitrated
//   WR_VALID/ADDR/DATA/READY: NW write requesters, round-robin arbitrated
//   RSP_VALID/ID/DATA/ERR: tagged read response, 2 edges after accept
//   WR_ERR             : pulse after an out-of-range write is dropped
//   M_*                : macro read port (A1/CSB1/OEB1/O1) and write port (A2/CSB2/WEB2/I2)
//   SRAM_2P_CTRL_BYPASS_EN: same-edge read/write to one address returns the write data
module sram_2p_ctrl
  import sram_2p_ctrl_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int AW    = AW_DEF,
  parameter int NR    = 4,
  parameter int NW    = 2,
  parameter int IDW   = IDW_DEF
) (
  input  logic             CE,
  input  logic             RST,
  input  logic [NR-1:0]    RD_VALID,
  input  logic [NR*AW-1:0] RD_ADDR,
  output logic [NR-1:0]    RD_READY,
  input  logic [NW-1:0]    WR_VALID,
  input  logic [NW*AW-1:0] WR_ADDR,
  input  logic [NW*DW-1:0] WR_DATA,
  output logic [NW-1:0]    WR_READY,
  output logic             RSP_VALID,
  output logic [IDW-1:0]   RSP_ID,
  output logic [DW-1:0]    RSP_DATA,
  output logic             RSP_ERR,
  output logic             WR_ERR,
  output logic [AW-1:0]    M_A1,
  output logic             M_CSB1,
  output logic             M_OEB1,
  input  logic [DW-1:0]    M_O1,
  output logic [AW-1:0]    M_A2,
  output logic             M_CSB2,
  output logic             M_WEB2,
  output logic [DW-1:0]    M_I2
);
  logic [NR-1:0] rd_gnt;
  logic [NW-1:0] wr_gnt;
  logic [AW-1:0] rd_addr, wr_addr, m_a1_q, m_a2_q;
  logic [DW-1:0] wr_data, m_i2_q, rsp_data_q, byp_data;
  logic [IDW_DEF-1:0] rd_id;
  logic [IDW-1:0] rsp_id_q;
  logic rd_acc, wr_acc, rd_go_d, wr_go_d, byp;
  logic m_csb1_q, m_csb2_q, v1_q, v2_q, rsp_v_q, rsp_err_q, wr_err_q;
  tag_t tag1_q, tag2_q;
  rr_arbiter #(.N(NR)) u_rd_arb (.clk(CE), .rst(RST), .req_i(RD_VALID), .acc_i(rd_acc), .gnt_o(rd_gnt));
  rr_arbiter #(.N(NW)) u_wr_arb (.clk(CE), .rst(RST), .req_i(WR_VALID), .acc_i(wr_acc), .gnt_o(wr_gnt));
  always_comb begin
    rd_addr = '0;
    rd_id = '0;
    for (int i = 0; i < NR; i++)
      if (rd_gnt[i]) begin
        rd_addr = RD_ADDR[i*AW +: AW];
        rd_id = IDW_DEF'(i);
      end
  end
  always_comb begin
    wr_addr = '0;
    wr_data = '0;
    for (int i = 0; i < NW; i++)
      if (wr_gnt[i]) begin
        wr_addr = WR_ADDR[i*AW +: AW];
        wr_data = WR_DATA[i*DW +: DW];
      end
  end
  assign rd_acc = |rd_gnt;
  assign wr_acc = |wr_gnt;
  assign rd_go_d = rd_acc && int'(rd_addr) < DEPTH;
  assign wr_go_d = wr_acc && int'(wr_addr) < DEPTH;
`ifdef SRAM_2P_CTRL_BYPASS_EN
  logic [DW-1:0] byp_data_q;
  // a legal read address equal to the write address implies the write is legal too
  assign byp = rd_go_d && wr_acc && rd_addr == wr_addr;
  // M_I2 still holds the colliding write's data one edge later; keep it for the response stage
  always_ff @(posedge CE) byp_data_q <= RST ? '0 : m_i2_q;
  assign byp_data = byp_data_q;
`else
  assign byp = 1'b0;
  assign byp_data = '0;
`endif
  always_ff @(posedge CE) begin
    if (RST) begin
      m_csb1_q <= 1'b1;
      m_csb2_q <= 1'b1;
      m_a1_q <= '0;
      m_a2_q <= '0;
      m_i2_q <= '0;
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      tag1_q <= '0;
      tag2_q <= '0;
      rsp_v_q <= 1'b0;
      rsp_err_q <= 1'b0;
      rsp_id_q <= '0;
      rsp_data_q <= '0;
      wr_err_q <= 1'b0;
    end else begin
      m_csb1_q <= !rd_go_d;
      m_csb2_q <= !wr_go_d;
      if (rd_go_d) m_a1_q <= rd_addr;
      if (wr_go_d) begin
        m_a2_q <= wr_addr;
        m_i2_q <= wr_data;
      end
      wr_err_q <= wr_acc && !wr_go_d;
      v1_q <= rd_acc;
      tag1_q <= '{id: rd_id, err: !rd_go_d, bypass: byp};
      v2_q <= v1_q;
      tag2_q <= tag1_q;
      rsp_v_q <= v2_q;
      rsp_err_q <= v2_q && tag2_q.err;
      if (v2_q) begin
        rsp_id_q <= IDW'(tag2_q.id);
        rsp_data_q <= tag2_q.err ? '0 : tag2_q.bypass ? byp_data : M_O1;
      end
    end
  end
  assign RD_READY = rd_gnt;
  assign WR_READY = wr_gnt;
  assign RSP_VALID = rsp_v_q;
  assign RSP_ID = rsp_id_q;
  assign RSP_DATA = rsp_data_q;
  assign RSP_ERR = rsp_err_q;
  assign WR_ERR = wr_err_q;
  assign M_A1 = m_a1_q;
  assign M_CSB1 = m_csb1_q;
  assign M_OEB1 = 1'b0;
  assign M_A2 = m_a2_q;
  assign M_CSB2 = m_csb2_q;
  assign M_WEB2 = m_csb2_q;
  assign M_I2 = m_i2_q;
endmodule

// File: tb/tb_sram_2p_ctrl.sv
// tb_sram_2p_ctrl: randomized and directed checks of sram_2p_ctrl against a memory/queue reference model
module tb_sram_2p_ctrl;
  localparam int DW = 128, DEPTH = 1296, AW = 11, NR = 4, NW = 2, IDW = 2;
`ifdef SRAM_2P_CTRL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic CE = 1'b0, RST = 1'b1;
  logic [NR-1:0] RD_VALID = '0, RD_READY;
  logic [NR*AW-1:0] RD_ADDR = '0;
  logic [NW-1:0] WR_VALID = '0, WR_READY;
  logic [NW*AW-1:0] WR_ADDR = '0;
  logic [NW*DW-1:0] WR_DATA = '0;
  logic RSP_VALID, RSP_ERR, WR_ERR, M_CSB1, M_OEB1, M_CSB2, M_WEB2;
  logic [IDW-1:0] RSP_ID;
  logic [DW-1:0] RSP_DATA, M_O1, M_I2;
  logic [AW-1:0] M_A1, M_A2;
  sram_2p_ctrl dut (
    .CE(CE), .RST(RST),
    .RD_VALID(RD_VALID), .RD_ADDR(RD_ADDR), .RD_READY(RD_READY),
    .WR_VALID(WR_VALID), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_READY(WR_READY),
    .RSP_VALID(RSP_VALID), .RSP_ID(RSP_ID), .RSP_DATA(RSP_DATA), .RSP_ERR(RSP_ERR), .WR_ERR(WR_ERR),
    .M_A1(M_A1), .M_CSB1(M_CSB1), .M_OEB1(M_OEB1), .M_O1(M_O1),
    .M_A2(M_A2), .M_CSB2(M_CSB2), .M_WEB2(M_WEB2), .M_I2(M_I2)
  );
  always #5 CE = ~CE;
  // registered-read two-port macro: a same-edge read sees the old word
  bit [DW-1:0] mem [DEPTH];
  always @(posedge CE) begin
    if (!M_CSB1) M_O1 <= mem[M_A1];
    if (!M_CSB2 && !M_WEB2) mem[M_A2] <= M_I2;
  end
  typedef struct {
    int due;
    int id;
    logic err;
    logic [DW-1:0] data;
  } rsp_t;
  rsp_t q[$];
  bit [DW-1:0] ref_mem [DEPTH];
  int checks = 0, failures = 0, cyc = 0, rptr = 0, wptr = 0;
  logic exp_werr = 1'b0, exp_csb1 = 1'b1, exp_csb2 = 1'b1;
  logic [AW-1:0] exp_a1 = '0, exp_a2 = '0;
  logic [DW-1:0] exp_i2 = '0;
  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  function automatic int pick(input logic [7:0] v, input int p, input int n);
    for (int k = 0; k < n; k++) if (v[(p + k) % n]) return (p + k) % n;
    return -1;
  endfunction
  function automatic logic [AW-1:0] raddr();
    int s = int'($urandom_range(9, 0));
    if (s < 7) return AW'($urandom_range(15, 0));
    if (s < 9) return AW'($urandom_range(DEPTH + 2, DEPTH - 2));
    return AW'($urandom_range(2047, 0));
  endfunction
  // one clock: check registered outputs and grants, then advance the model across the edge
  task automatic cycle();
    int ri, wi;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd;
    logic rst_e;
    rsp_t r;
    @(negedge CE);
    if (q.size() > 0 && q[0].due == cyc) begin
      check("rsp_valid", RSP_VALID, 1);
      check("rsp_id", RSP_ID, q[0].id);
      check("rsp_err", RSP_ERR, q[0].err);
      check("rsp_data", RSP_DATA, q[0].data);
      void'(q.pop_front());
    end else check("rsp_valid", RSP_VALID, 0);
    check("wr_err", WR_ERR, exp_werr);
    check("m_csb1", M_CSB1, exp_csb1);
    check("m_oeb1", M_OEB1, 0);
    check("m_csb2", M_CSB2, exp_csb2);
    check("m_web2", M_WEB2, exp_csb2);
    if (!exp_csb1) check("m_a1", M_A1, exp_a1);
    if (!exp_csb2) begin
      check("m_a2", M_A2, exp_a2);
      check("m_i2", M_I2, exp_i2);
    end
    ri = pick(8'(RD_VALID), rptr, NR);
    wi = pick(8'(WR_VALID), wptr, NW);
    check("rd_ready", RD_READY, ri < 0 ? 0 : 1 << ri);
    check("wr_ready", WR_READY, wi < 0 ? 0 : 1 << wi);
    ra = '0;
    wa = '0;
    wd = '0;
    if (ri >= 0) ra = RD_ADDR[ri*AW +: AW];
    if (wi >= 0) begin
      wa = WR_ADDR[wi*AW +: AW];
      wd = WR_DATA[wi*DW +: DW];
    end
    rst_e = RST;
    @(posedge CE);
    cyc++;
    if (rst_e) begin
      q.delete();
      rptr = 0;
      wptr = 0;
      exp_werr = 1'b0;
      exp_csb1 = 1'b1;
      exp_csb2 = 1'b1;
    end else begin
      exp_werr = wi >= 0 && int'(wa) >= DEPTH;
      exp_csb1 = !(ri >= 0 && int'(ra) < DEPTH);
      exp_csb2 = !(wi >= 0 && int'(wa) < DEPTH);
      if (!exp_csb1) exp_a1 = ra;
      if (!exp_csb2) begin
        exp_a2 = wa;
        exp_i2 = wd;
      end
      if (ri >= 0) begin
        r.due = cyc + 2;
        r.id = ri;
        r.err = int'(ra) >= DEPTH;
        r.data = r.err ? '0 : (BYP && !exp_csb2 && wa == ra) ? wd : ref_mem[ra];
        q.push_back(r);
        rptr = (ri + 1) % NR;
      end
      if (wi >= 0) begin
        if (!exp_csb2) ref_mem[wa] = wd;
        wptr = (wi + 1) % NW;
      end
    end
    #1;
    if (!rst_e && ri >= 0) RD_VALID[ri] = 1'b0;
    if (!rst_e && wi >= 0) WR_VALID[wi] = 1'b0;
  endtask
  initial begin
    repeat (3) cycle();
    RST = 1'b0;
    check("rst_rsp_data", RSP_DATA, 0);
    check("rst_rsp_id", RSP_ID, 0);
    check("rst_m_a1", M_A1, 0);
    check("rst_m_i2", M_I2, 0);
    repeat (2) cycle();
    WR_VALID[1] = 1'b1;
    WR_ADDR[AW +: AW] = 11'd5;
    WR_DATA[DW +: DW] = {16{8'hA5}};
    cycle();
    RD_VALID[2] = 1'b1;
    RD_ADDR[2*AW +: AW] = 11'd5;
    repeat (4) cycle();
    for (int i = 0; i < NR; i++) RD_ADDR[i*AW +: AW] = AW'(5 + i);
    repeat (5) begin
      RD_VALID = '1;
      cycle();
    end
    repeat (3) cycle();
    RD_VALID[0] = 1'b1;
    RD_ADDR[0 +: AW] = AW'(DEPTH);
    WR_VALID[0] = 1'b1;
    WR_ADDR[0 +: AW] = 11'd2000;
    WR_DATA[0 +: DW] = '1;
    repeat (4) cycle();
    WR_VALID[0] = 1'b1;
    WR_ADDR[0 +: AW] = 11'd7;
    WR_DATA[0 +: DW] = DW'(8'h11);
    cycle();
    WR_VALID[0] = 1'b1;
    WR_DATA[0 +: DW] = DW'(8'h22);
    RD_VALID[1] = 1'b1;
    RD_ADDR[AW +: AW] = 11'd7;
    repeat (4) cycle();
    RD_VALID[1] = 1'b1;
    RD_ADDR[AW +: AW] = 11'd9;
    WR_VALID[0] = 1'b1;
    WR_ADDR[0 +: AW] = 11'd12;
    cycle();
    RST = 1'b1;
    cycle();
    RST = 1'b0;
    repeat (3) cycle();
    RD_VALID[0] = 1'b1;
    RD_VALID[3] = 1'b1;
    RD_ADDR[0 +: AW] = 11'd5;
    RD_ADDR[3*AW +: AW] = 11'd12;
    WR_VALID = '1;
    WR_ADDR = {11'd3, 11'd4};
    repeat (5) cycle();
    repeat (400) begin
      for (int i = 0; i < NR; i++)
        if (!RD_VALID[i] && $urandom_range(1, 0) == 1) begin
          RD_ADDR[i*AW +: AW] = raddr();
          RD_VALID[i] = 1'b1;
        end
      for (int i = 0; i < NW; i++)
        if (!WR_VALID[i] && $urandom_range(2, 0) == 0) begin
          WR_ADDR[i*AW +: AW] = raddr();
          WR_DATA[i*DW +: DW] = {$urandom, $urandom, $urandom, $urandom};
          WR_VALID[i] = 1'b1;
        end
      cycle();
    end
    repeat (12) cycle();
    check("rsp_drained", DW'(q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
